// File: rtl/fma_read_buffer.sv
// fma_read_buffer: holds up to DEPTH memory lines and streams each one out as BEATS beats of FMA_COUNT words.
// Defining FMA_READ_BUFFER_FLUSH_EN adds a synchronous flush_in port.
module fma_read_buffer #(
  parameter int FMA_COUNT  = 2,
  parameter int WORD_WIDTH = 16,
  parameter int LINE_WIDTH = 96,
  parameter int DEPTH      = 2,
  localparam int BEAT_W    = WORD_WIDTH * FMA_COUNT,
  localparam int BEATS     = LINE_WIDTH / BEAT_W,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
`ifdef FMA_READ_BUFFER_FLUSH_EN
  input  logic                  flush_in,
`endif
  input  logic [LINE_WIDTH-1:0] line_in,
  input  logic                  line_valid_in,
  output logic                  line_ready_out,
  output logic [BEAT_W-1:0]     beat_out,
  output logic                  beat_valid_out,
  input  logic                  beat_ready_in,
  output logic                  last_beat_out,
  output logic [CNT_W-1:0]      count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  logic [LINE_WIDTH-1:0] mem [DEPTH];
  logic [BEAT_W-1:0]     beat_slice [BEATS];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] beat_idx_q, beat_idx_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic flush;
  logic push;
  logic pop;
  logic retire;

`ifdef FMA_READ_BUFFER_FLUSH_EN
  assign flush = flush_in;
`else
  assign flush = 1'b0;
`endif

  // Ready comes from the registered count only, so a full buffer reopens one cycle after retiring.
  assign line_ready_out = (count_q != CNT_W'(DEPTH));
  assign beat_valid_out = (count_q != '0);
  assign last_beat_out  = beat_valid_out && (beat_idx_q == LAST_IDX);
  assign count_out      = count_q;

  assign push   = line_valid_in && line_ready_out && !flush;
  assign pop    = beat_valid_out && beat_ready_in;
  assign retire = pop && (beat_idx_q == LAST_IDX);

  // Beat 0 is the most significant slice of the head line.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
    assign beat_slice[gi] = mem[rd_ptr_q][LINE_WIDTH-1-gi*BEAT_W -: BEAT_W];
  end

  assign beat_out = beat_valid_out ? beat_slice[beat_idx_q] : '0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_idx_d = beat_idx_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      beat_idx_d = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (retire) begin
        beat_idx_d = '0;
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      end else if (pop) begin
        beat_idx_d = beat_idx_q + IDX_W'(1);
      end
      if (push && !retire) begin
        count_d = count_q + CNT_W'(1);
      end else if (retire && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_idx_q <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_idx_q <= beat_idx_d;
      count_q    <= count_d;
    end
  end

  // Line storage has no reset; stale contents are never visible because beat_out is gated by count.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr_q] <= line_in;
    end
  end

endmodule

// File: tb/tb_fma_read_buffer.sv
// Scoreboard bench for fma_read_buffer: stimulus pushes lines, a negedge monitor checks every beat.
// Define FMA_READ_BUFFER_FLUSH_EN to also exercise flush_in.
module tb_fma_read_buffer;
  localparam int LINE_WIDTH = 96;
  localparam int BEAT_W     = 32;
  localparam int BEATS      = 3;
  localparam int DEPTH      = 2;
  localparam int CNT_W      = 2;

  logic                  clk_in = 1'b0;
  logic                  rst_in = 1'b0;
  logic [LINE_WIDTH-1:0] line_in = '0;
  logic                  line_valid_in = 1'b0;
  logic                  line_ready_out;
  logic [BEAT_W-1:0]     beat_out;
  logic                  beat_valid_out;
  logic                  beat_ready_in = 1'b0;
  logic                  last_beat_out;
  logic [CNT_W-1:0]      count_out;
`ifdef FMA_READ_BUFFER_FLUSH_EN
  logic                  flush_in = 1'b0;
`endif

  fma_read_buffer #(
    .FMA_COUNT(2), .WORD_WIDTH(16), .LINE_WIDTH(LINE_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
`ifdef FMA_READ_BUFFER_FLUSH_EN
    .flush_in(flush_in),
`endif
    .line_in(line_in),
    .line_valid_in(line_valid_in),
    .line_ready_out(line_ready_out),
    .beat_out(beat_out),
    .beat_valid_out(beat_valid_out),
    .beat_ready_in(beat_ready_in),
    .last_beat_out(last_beat_out),
    .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_exp;
  int   n_vec = 0;
  int   n_err = 0;
  int   model_cnt = 0;
  int   pop_cnt = 0;
  bit   m_push;
  bit   m_retire;
  bit   src_done;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares handshake state and popped beats against the line-level model.
  always @(negedge clk_in) begin
    if (rst_in) begin
`ifdef FMA_READ_BUFFER_FLUSH_EN
      if (flush_in) begin
        exp_q.delete();
        model_cnt = 0;
      end else
`endif
      begin
        check("count_out", count_out, model_cnt);
        check("line_ready_out", line_ready_out, model_cnt != DEPTH);
        check("beat_valid_out", beat_valid_out, model_cnt != 0);
        m_retire = 1'b0;
        if (beat_valid_out && beat_ready_in) begin
          if (exp_q.size() == 0) begin
            check("unexpected beat", 1, 0);
          end else begin
            m_exp = exp_q.pop_front();
            check("beat_out", beat_out, m_exp.data);
            check("last_beat_out", last_beat_out, m_exp.last);
            m_retire = m_exp.last;
            pop_cnt++;
          end
        end
        m_push = line_valid_in && (model_cnt != DEPTH);
        if (m_push) begin
          for (int k = 0; k < BEATS; k++) begin
            m_exp.data = line_in[LINE_WIDTH-1-k*BEAT_W -: BEAT_W];
            m_exp.last = (k == BEATS - 1);
            exp_q.push_back(m_exp);
          end
        end
        model_cnt = model_cnt + int'(m_push) - int'(m_retire);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic push_line(input logic [LINE_WIDTH-1:0] l);
    int   t;
    logic acc;
    t = 0;
    line_in = l;
    line_valid_in = 1'b1;
    while (1) begin
      @(negedge clk_in);
      acc = line_ready_out;
      @(posedge clk_in);
      #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        check("push timeout", 0, 1);
        break;
      end
    end
    line_valid_in = 1'b0;
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 3000 && model_cnt != 0; t++) @(negedge clk_in);
    if (model_cnt != 0) check("drain timeout", model_cnt, 0);
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [BEAT_W-1:0]     hand2 [3];
  logic [LINE_WIDTH-1:0] l;
  int                    p0;

  initial begin
    hand2[0] = 32'h00010002;
    hand2[1] = 32'h00030004;
    hand2[2] = 32'h00050006;

    // Reset state
    #12;
    check("reset beat_valid", beat_valid_out, 0);
    check("reset line_ready", line_ready_out, 1);
    check("reset count", count_out, 0);
    check("reset beat_out", beat_out, 0);
    check("reset last", last_beat_out, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Single line, ready held high
    beat_ready_in = 1'b1;
    push_line(96'h0001_0002_0003_0004_0005_0006);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check("single valid", beat_valid_out, 1);
      check("single beat", beat_out, hand2[k]);
      check("single last", last_beat_out, k == 2);
      @(posedge clk_in);
      #1;
    end
    wait_empty();

    // Backpressure: two lines fill the buffer, third is refused
    beat_ready_in = 1'b0;
    push_line(96'h1111_2222_3333_4444_5555_6666);
    push_line(96'h7777_8888_9999_aaaa_bbbb_cccc);
    line_in = 96'hdddd_eeee_ffff_0123_4567_89ab;
    line_valid_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      check("bp held beat", beat_out, 32'h11112222);
      check("bp count", count_out, 2);
      check("bp ready", line_ready_out, 0);
    end
    @(posedge clk_in);
    #1;
    line_valid_in = 1'b0;
    beat_ready_in = 1'b1;
    wait_empty();

    // Asynchronous reset mid-line, then the next line starts at beat 0
    beat_ready_in = 1'b0;
    push_line(96'h0a0a_0b0b_0c0c_0d0d_0e0e_0f0f);
    beat_ready_in = 1'b1;
    @(posedge clk_in);
    #2;
    beat_ready_in = 1'b0;
    rst_in = 1'b0;
    #1;
    check("midreset beat_valid", beat_valid_out, 0);
    check("midreset line_ready", line_ready_out, 1);
    check("midreset count", count_out, 0);
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    beat_ready_in = 1'b1;
    push_line(96'h5a5a_a5a5_1234_5678_9abc_def0);
    @(negedge clk_in);
    check("post-reset beat0", beat_out, 32'h5a5aa5a5);
    @(posedge clk_in);
    #1;
    wait_empty();

    // Steady stream of 8 lines, no gaps on the beat side
    beat_ready_in = 1'b1;
    p0 = pop_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          for (int w = 0; w < 6; w++) l[LINE_WIDTH-1-w*16 -: 16] = 16'(16'hA000 + i*16 + w);
          push_line(l);
        end
      end
      begin
        int t;
        t = 0;
        while (pop_cnt == p0 && t < 100) begin
          @(posedge clk_in);
          t++;
        end
        repeat (23) @(posedge clk_in);
        check("stream beats in 24 cycles", pop_cnt - p0, 24);
      end
    join
    wait_empty();
    check("stream final count", count_out, 0);

    // Random ready on both sides, 200 lines
    src_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk_in);
            #1;
          end
          push_line({$urandom, $urandom, $urandom});
        end
        src_done = 1'b1;
      end
      begin
        while (!src_done) begin
          beat_ready_in = 1'($urandom_range(0, 1));
          @(posedge clk_in);
          #1;
        end
      end
    join
    beat_ready_in = 1'b1;
    wait_empty();

`ifdef FMA_READ_BUFFER_FLUSH_EN
    // Flush after beat 1 of two queued lines
    beat_ready_in = 1'b0;
    push_line(96'h1357_2468_1357_2468_1357_2468);
    push_line(96'h0f0f_f0f0_0f0f_f0f0_0f0f_f0f0);
    beat_ready_in = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    beat_ready_in = 1'b0;
    flush_in = 1'b1;
    @(posedge clk_in);
    #1;
    flush_in = 1'b0;
    check("flush beat_valid", beat_valid_out, 0);
    check("flush count", count_out, 0);
    check("flush line_ready", line_ready_out, 1);
    beat_ready_in = 1'b1;
    push_line(96'hcafe_babe_dead_beef_f00d_1234);
    @(negedge clk_in);
    check("post-flush beat0", beat_out, 32'hcafebabe);
    @(posedge clk_in);
    #1;
    wait_empty();
`endif

    check("scoreboard empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
